// File: rtl/trace_arbiter.sv
// Round-robin arbiter sharing one cpu_checker among four character-trace sources:
// locks a source from '^' to '#', streams the line, and tags the verdict with the source.
module trace_arbiter #(
  parameter int unsigned LINE_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  src_valid,
  input  logic [31:0] src_char,
  output logic [3:0]  src_ready,
  output logic [7:0]  chk_char,
  output logic        chk_reset,
  input  logic [1:0]  chk_format_type,
  input  logic [3:0]  chk_error_code,
  output logic        res_valid,
  output logic [1:0]  res_src,
  output logic [1:0]  res_format,
  output logic [3:0]  res_error,
  output logic        res_abort
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned LW   = 7;
  localparam logic [CW-1:0] CH_HEAD   = 8'h5E;
  localparam logic [CW-1:0] CH_TAIL   = 8'h23;
  localparam logic [LW-1:0] LEN_LIMIT = LW'(LINE_MAX);

  typedef enum logic [1:0] {IDLE, GRANT, DONE, ABORT} state_t;

  state_t        state, state_d;
  logic [1:0]    ptr, ptr_d, gnt, gnt_d, pick, idx;
  logic [LW-1:0] len, len_d, len_inc;
  logic [3:0]    cand, junk, ready_c;
  logic [CW-1:0] gnt_char;
  logic          chk_reset_d;
  logic          res_valid_d, res_abort_d;
  logic [1:0]    res_src_d, res_format_d;
  logic [3:0]    res_error_d;

  // Classify each head character: '^' bids for the checker, anything else is junk.
  always_comb begin
    cand = '0;
    junk = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (src_valid[i]) begin
        if (src_char[CW*i +: CW] == CH_HEAD) cand[i] = 1'b1;
        else                                 junk[i] = 1'b1;
      end
    end
  end

  // First candidate at or after ptr; scanning downward lets the nearest one win.
  always_comb begin
    pick = ptr;
    idx  = ptr;
    for (int k = int'(NSRC) - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (cand[idx]) pick = idx;
    end
  end

  assign gnt_char = src_char[{gnt, 3'b000} +: CW];
  assign len_inc  = len + LW'(1);

  // Next-state and output decode.
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    gnt_d        = gnt;
    len_d        = len;
    ready_c      = '0;
    chk_char     = '0;
    chk_reset_d  = 1'b0;
    res_valid_d  = 1'b0;
    res_src_d    = res_src;
    res_format_d = res_format;
    res_error_d  = res_error;
    res_abort_d  = res_abort;
    case (state)
      IDLE: begin
        ready_c = junk;
        if (|cand) begin
          gnt_d   = pick;
          len_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ready_c[gnt] = src_valid[gnt];
        if (src_valid[gnt]) begin
          chk_char = gnt_char;
          len_d    = len_inc;
          if (gnt_char == CH_TAIL)       state_d = DONE;
          else if (len_inc == LEN_LIMIT) state_d = ABORT;
        end else begin
          state_d = ABORT;
        end
        // Abort verdict and checker flush both land in the ABORT cycle.
        if (state_d == ABORT) begin
          chk_reset_d  = 1'b1;
          res_valid_d  = 1'b1;
          res_src_d    = gnt;
          res_format_d = '0;
          res_error_d  = '0;
          res_abort_d  = 1'b1;
        end
      end
      DONE: begin
        res_valid_d  = 1'b1;
        res_src_d    = gnt;
        res_format_d = chk_format_type;
        res_error_d  = chk_error_code;
        res_abort_d  = 1'b0;
        ptr_d        = gnt + 2'd1;
        state_d      = IDLE;
      end
      ABORT: begin
        ptr_d   = gnt + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Nothing is consumed while reset is held.
  assign src_ready = reset ? ready_c : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      len        <= '0;
      chk_reset  <= 1'b1;
      res_valid  <= 1'b0;
      res_src    <= '0;
      res_format <= '0;
      res_error  <= '0;
      res_abort  <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      gnt        <= gnt_d;
      len        <= len_d;
      chk_reset  <= chk_reset_d;
      res_valid  <= res_valid_d;
      res_src    <= res_src_d;
      res_format <= res_format_d;
      res_error  <= res_error_d;
      res_abort  <= res_abort_d;
    end
  end

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: one default-length instance and one with LINE_MAX=8.
module tb_trace_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_valid;
  logic [31:0] src_char;
  logic [3:0]  src_ready;
  logic [7:0]  chk_char;
  logic        chk_reset;
  logic [1:0]  chk_format_type;
  logic [3:0]  chk_error_code;
  logic        res_valid;
  logic [1:0]  res_src;
  logic [1:0]  res_format;
  logic [3:0]  res_error;
  logic        res_abort;

  logic [3:0]  s_valid;
  logic [31:0] s_char;
  logic [3:0]  s_ready;
  logic [7:0]  s_chk_char;
  logic        s_chk_reset;
  logic [1:0]  s_fmt;
  logic [3:0]  s_err;
  logic        s_res_valid;
  logic [1:0]  s_res_src;
  logic [1:0]  s_res_format;
  logic [3:0]  s_res_error;
  logic        s_res_abort;

  int    checks   = 0;
  int    failures = 0;
  string line [4];
  int    pos  [4];
  int    exp_q [$];
  string ol_bad  = "^abcdefg";
  string ol_good = "^abcdef#";

  always #5 clk = ~clk;

  trace_arbiter #(.LINE_MAX(64)) u_dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_char(src_char), .src_ready(src_ready),
    .chk_char(chk_char), .chk_reset(chk_reset),
    .chk_format_type(chk_format_type), .chk_error_code(chk_error_code),
    .res_valid(res_valid), .res_src(res_src), .res_format(res_format),
    .res_error(res_error), .res_abort(res_abort)
  );

  trace_arbiter #(.LINE_MAX(8)) u_short (
    .clk(clk), .reset(reset),
    .src_valid(s_valid), .src_char(s_char), .src_ready(s_ready),
    .chk_char(s_chk_char), .chk_reset(s_chk_reset),
    .chk_format_type(s_fmt), .chk_error_code(s_err),
    .res_valid(s_res_valid), .res_src(s_res_src), .res_format(s_res_format),
    .res_error(s_res_error), .res_abort(s_res_abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  // Present each source's next character from its line string.
  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      if (pos[i] < line[i].len()) begin
        src_valid[i]       = 1'b1;
        src_char[8*i +: 8] = line[i][pos[i]];
      end else begin
        src_valid[i]       = 1'b0;
        src_char[8*i +: 8] = 8'h00;
      end
    end
  endtask

  // Advance one cycle, popping characters that were accepted.
  task automatic step();
    logic [3:0] rdy;
    rdy = src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (rdy[i]) pos[i]++;
    apply();
    #1;
  endtask

  task automatic clear_lines();
    for (int i = 0; i < 4; i++) begin
      line[i] = "";
      pos[i]  = 0;
    end
    apply();
  endtask

  // Run a bounded number of cycles matching verdicts against exp_q in order.
  task automatic run_collect(input int budget, input logic abort_exp, input logic [1:0] fmt_exp);
    logic prev;
    prev = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_verdict", res_valid, 1'b0);
        end else begin
          check("verdict_src", res_src, exp_q.pop_front());
          check("verdict_abort", res_abort, abort_exp);
          check("verdict_format", res_format, fmt_exp);
        end
      end
      check("no_back_to_back", prev & res_valid, 1'b0);
      prev = res_valid;
    end
    check("missing_verdicts", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    src_valid = '0; src_char = '0; chk_format_type = '0; chk_error_code = '0;
    s_valid = '0; s_char = '0; s_fmt = '0; s_err = '0;
    clear_lines();
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst_chk_reset", chk_reset, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_src", res_src, 2'd0);
    check("rst_res_format", res_format, 2'd0);
    check("rst_res_error", res_error, 4'd0);
    check("rst_res_abort", res_abort, 1'b0);
    check("rst_chk_char", chk_char, 8'h00);
    check("rst_short_chk_reset", s_chk_reset, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("chk_reset_release", chk_reset, 1'b0);

    // Single line on src1
    line[1] = "^10@00003000: $ 1 <= 0000000A#";
    apply();
    #1;
    check("t1_idle_ready", src_ready, 4'b0000);
    check("t1_idle_char", chk_char, 8'h00);
    for (int k = 0; k < 30; k++) begin
      step();
      check("t1_char", chk_char, line[1][k]);
      check("t1_ready", src_ready, 4'b0010);
    end
    chk_format_type = 2'd1;
    chk_error_code  = 4'b0100;
    step();
    check("t1_done_char", chk_char, 8'h00);
    check("t1_done_novalid", res_valid, 1'b0);
    step();
    check("t1_res_valid", res_valid, 1'b1);
    check("t1_res_src", res_src, 2'd1);
    check("t1_res_format", res_format, 2'd1);
    check("t1_res_error", res_error, 4'b0100);
    check("t1_res_abort", res_abort, 1'b0);
    step();
    check("t1_single_pulse", res_valid, 1'b0);

    // Round-robin from reset, src0 holds two lines
    reset = 1'b0;
    chk_format_type = 2'd2;
    chk_error_code  = 4'h9;
    line[0] = "^0#^4#"; line[1] = "^1#"; line[2] = "^2#"; line[3] = "^3#";
    for (int i = 0; i < 4; i++) pos[i] = 0;
    apply();
    #1;
    check("rr_reset_ready", src_ready, 4'b0000);
    step();
    reset = 1'b1;
    exp_q = '{0, 1, 2, 3, 0};
    run_collect(40, 1'b0, 2'd2);

    // Mid-line stall on src2 after five characters
    clear_lines();
    line[2] = "^abcd";
    apply();
    #1;
    check("st_idle_ready", src_ready, 4'b0000);
    repeat (5) step();
    check("st_last_char", chk_char, 8'h64);
    step();
    check("st_stall_char", chk_char, 8'h00);
    check("st_stall_ready", src_ready, 4'b0000);
    check("st_stall_no_flush", chk_reset, 1'b0);
    step();
    check("st_flush", chk_reset, 1'b1);
    check("st_res_valid", res_valid, 1'b1);
    check("st_res_abort", res_abort, 1'b1);
    check("st_res_src", res_src, 2'd2);
    check("st_res_format", res_format, 2'd0);
    check("st_res_error", res_error, 4'd0);
    step();
    check("st_flush_one_cycle", chk_reset, 1'b0);
    check("st_pulse_one_cycle", res_valid, 1'b0);

    // ptr now 3: src3 beats src0
    clear_lines();
    line[0] = "^#"; line[3] = "^#";
    apply();
    #1;
    check("ptr_idle_ready", src_ready, 4'b0000);
    step();
    check("ptr_grant_src3", src_ready, 4'b1000);
    exp_q = '{3, 0};
    run_collect(16, 1'b0, 2'd2);

    // Overlength on LINE_MAX=8, then '#' as the eighth character
    s_valid = 4'b0001;
    s_char  = {24'h0, 8'h5E};
    #1;
    check("ol_idle_ready", s_ready, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      s_char[7:0] = ol_bad[k];
      #1;
      check("ol_char", s_chk_char, ol_bad[k]);
      check("ol_ready", s_ready, 4'b0001);
      check("ol_no_early_abort", s_res_valid, 1'b0);
    end
    @(posedge clk); #1;
    s_valid = '0;
    #1;
    check("ol_flush", s_chk_reset, 1'b1);
    check("ol_res_valid", s_res_valid, 1'b1);
    check("ol_res_abort", s_res_abort, 1'b1);
    check("ol_res_src", s_res_src, 2'd0);
    @(posedge clk); #1;
    s_valid = 4'b0001;
    s_char  = {24'h0, 8'h5E};
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      s_char[7:0] = ol_good[k];
      #1;
      check("ok8_char", s_chk_char, ol_good[k]);
    end
    @(posedge clk); #1;
    s_valid = '0;
    s_fmt   = 2'd3;
    s_err   = 4'hA;
    #1;
    check("ok8_done_no_flush", s_chk_reset, 1'b0);
    check("ok8_done_novalid", s_res_valid, 1'b0);
    @(posedge clk); #1;
    check("ok8_res_valid", s_res_valid, 1'b1);
    check("ok8_res_abort", s_res_abort, 1'b0);
    check("ok8_res_format", s_res_format, 2'd3);
    check("ok8_res_error", s_res_error, 4'hA);

    // Junk drop on src3 ahead of '^'
    clear_lines();
    line[3] = "abc^#";
    apply();
    #1;
    check("junk_a", src_ready, 4'b1000);
    step();
    check("junk_b", src_ready, 4'b1000);
    step();
    check("junk_c", src_ready, 4'b1000);
    step();
    check("junk_head_held", src_ready, 4'b0000);
    step();
    check("junk_grant_ready", src_ready, 4'b1000);
    check("junk_grant_char", chk_char, 8'h5E);
    exp_q = '{3};
    run_collect(10, 1'b0, 2'd2);

    // Drop on src0 and grant to src1 in the same IDLE cycle
    clear_lines();
    line[0] = "q"; line[1] = "^#";
    apply();
    #1;
    check("mix_idle_ready", src_ready, 4'b0001);
    step();
    check("mix_grant_ready", src_ready, 4'b0010);
    exp_q = '{1};
    run_collect(10, 1'b0, 2'd2);

    // Async reset in the middle of a line
    clear_lines();
    line[2] = "^abcdefgh#";
    apply();
    #1;
    step();
    step();
    check("ar_pre_char", chk_char, 8'h61);
    reset = 1'b0;
    #1;
    check("ar_chk_reset", chk_reset, 1'b1);
    check("ar_chk_char", chk_char, 8'h00);
    check("ar_ready", src_ready, 4'b0000);
    check("ar_res_valid", res_valid, 1'b0);
    check("ar_res_src", res_src, 2'd0);
    check("ar_res_format", res_format, 2'd0);
    clear_lines();
    step();
    step();
    check("ar_hold_chk_reset", chk_reset, 1'b1);
    reset = 1'b1;
    step();
    check("ar_release", chk_reset, 1'b0);
    exp_q.delete();
    run_collect(8, 1'b0, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_arbiter.md
# trace_arbiter

Round-robin arbiter that shares one `cpu_checker` instance among four independent character-trace sources. Each source offers one character per cycle under a valid/ready handshake. The arbiter locks onto a source from its `^` to its `#`, streams the line contiguously into the checker, and captures the checker verdict tagged with the source index. Lines that stall mid-stream or run too long are aborted, and the checker is flushed. The block sits between the trace producers and the checker's `char` / `reset` inputs.

## Interface
- `LINE_MAX`, default 64: maximum characters per line, counting `^` and `#`; range 2..127.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `src_valid` input 4: bit i = source i presents a character.
- `src_char` input 32: source i character on `[8i+7:8i]`.
- `src_ready` output 4: bit i = character of source i consumed this cycle; combinational.
- `chk_char` output 8: character to checker `char`; combinational; 8'h00 when nothing is forwarded.
- `chk_reset` output 1: drives checker `reset` (active-high, synchronous); registered.
- `chk_format_type` input 2: checker `format_type`.
- `chk_error_code` input 4: checker `error_code`.
- `res_valid` output 1: one-cycle pulse, verdict available.
- `res_src` output 2: source index of the verdict.
- `res_format` output 2: captured `chk_format_type`; 0 on abort.
- `res_error` output 4: captured `chk_error_code`; 0 on abort.
- `res_abort` output 1: line was aborted, not judged.

## Operation
- **State `IDLE`**
  - A source is a candidate when `src_valid[i]` is high and `src_char[i]` == 8'h5E (`^`).
  - Any source with valid high and a head character other than `^` gets `src_ready[i]`=1, so that character is dropped. This applies to all such sources in the same cycle.
  - If any candidate exists, choose the first candidate searching from `ptr` upward, mod 4. Register it as `gnt`, clear `len`, and go to `GRANT`. The `^` is not consumed in this cycle.
- **State `GRANT`**
  - Only `src_ready[gnt]` can be high, and it equals `src_valid[gnt]`. All other ready bits are 0.
  - When `src_valid[gnt]`=1: `chk_char` = `src_char[gnt]` and `len` increments.
    - If the character is `#` (8'h23), go to `DONE`.
    - Otherwise, if `len+1` == `LINE_MAX`, go to `ABORT`.
  - When `src_valid[gnt]`=0: this is a stall. `chk_char`=8'h00; go to `ABORT`.
- **State `DONE`**
  - `chk_char`=8'h00.
  - Register `res_*` from the `chk_*` inputs with `res_abort`=0, and pulse `res_valid`.
  - Set `ptr` = `gnt+1` mod 4 and go to `IDLE`.
- **State `ABORT`**
  - `chk_reset`=1 for exactly the following cycle.
  - Pulse `res_valid` with `res_abort`=1 and `res_format`/`res_error`=0.
  - Set `ptr` = `gnt+1` mod 4 and go to `IDLE`.
- `len` is a 7-bit counter, cleared on grant. No other arithmetic is performed.

## Timing
- **Reset values:**
  - state=`IDLE`, `ptr`=0, `gnt`=0.
  - `res_valid`=0, `res_src`=0, `res_format`=0, `res_error`=0, `res_abort`=0.
  - `chk_reset`=1.
- `chk_reset` deasserts on the first rising edge after `reset` goes high, unless an abort is pending.
- **Grant latency:** `^` presented in cycle n (IDLE) is forwarded in cycle n+1.
- **Verdict timing:**
  - The checker registers `#` at the end of cycle k; its outputs are valid in cycle k+1 (`DONE`).
  - `res_*` are registered at the end of k+1 and visible in k+2.
  - The minimum line-to-line gap is 2 cycles: `DONE`, then `IDLE`.
- **Abort timing:** `chk_reset` is high in cycle a+1, where a is the abort cycle. `res_valid` is in the same cycle a+1.
- `res_valid` is never high on two consecutive cycles.
- **Boundaries:**
  - A `#` arriving as character number `LINE_MAX` completes normally; the `#` check takes precedence over the length check.
  - Simultaneous `^` on all sources: grant order is `ptr`, `ptr+1`, …
  - A non-`^` drop and a `^` grant may occur in the same `IDLE` cycle for different sources.
  - `reset` asserted mid-line drops the line immediately with no verdict. `chk_reset`=1 while reset is asserted.

## Test plan
- **Single line:** src1 streams `^10@00003000: $ 1 <= 0000000A#` back-to-back; stub `chk_format_type`=1, `chk_error_code`=4'b0100 in the `DONE` cycle. Required: exactly one `res_valid` with `res_src`=1, `res_format`=1, `res_error`=4'b0100, `res_abort`=0; `chk_char` matches the stream with a 1-cycle grant delay.
- **Round-robin:** all four sources hold a line starting with `^` from reset. Required: verdicts arrive in source order 0,1,2,3; a fifth line from src0 is granted after src3.
- **Mid-line stall:** src2 drops `src_valid` after 5 characters. Required: `chk_char`=00 in the stall cycle, `chk_reset`=1 for one cycle, `res_abort`=1, `res_src`=2, `ptr`=3.
- **Overlength:** `LINE_MAX`=8, src0 sends 8 characters without `#`. Required: abort. Separately, a 7-character line plus `#` as character 8 completes normally.
- **Junk drop:** src3 presents `abc` then `^`. Required: `src_ready[3]`=1 for `a`, `b`, `c` in IDLE; the grant follows on `^`.
- **Async reset mid-line:** `reset` low during `GRANT`. Required: all outputs return to reset values immediately, `chk_reset`=1, and no `res_valid`.
